// File: rtl/register_file.sv
// register_file: 24-bit GPR file feeding the ALU A/B operand buses.
// R0 reads as zero and has no storage; R1..R(N-1) clear asynchronously on reset.
// Reads are purely combinational from stored state with no write bypass, so
// the single-cycle loop (read -> ALU -> WriteData) stays free of comb cycles.

// One storage register; written on the rising edge when selected.
module register_file_cell #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Async clear wins over any write in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= '0;
    else if (we) q <= d;
  end

endmodule

module register_file #(
  parameter int WIDTH  = 24,
  parameter int ADDR_W = 2
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] RS,
  input  logic [ADDR_W-1:0] RT,
  input  logic [ADDR_W-1:0] RD,
  input  logic [WIDTH-1:0]  WriteData,
  input  logic [ADDR_W-1:0] DbgAddr,
  output logic [WIDTH-1:0]  ReadData1,
  output logic [WIDTH-1:0]  ReadData2,
  output logic [WIDTH-1:0]  DbgData
);

  localparam int NREGS = 2**ADDR_W;

  typedef struct packed {
    logic              en;
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  data;
  } wr_req_t;

  wr_req_t                       wr;
  logic [NREGS-1:0]              wsel;
  logic [NREGS-1:0][WIDTH-1:0]   regs;

  assign wr = '{en: RegWrite, addr: RD, data: WriteData};

  // One-hot write select; slot 0 never selected so R0 writes are dropped.
  always_comb begin
    wsel = '0;
    for (int i = 1; i < NREGS; i++)
      wsel[i] = wr.en && (wr.addr == ADDR_W'(i));
  end

  assign regs[0] = '0;

  genvar g;
  generate
    for (g = 1; g < NREGS; g++) begin : g_reg
      register_file_cell #(.WIDTH(WIDTH)) u_cell (
        .clk   (Clock),
        .rst_n (Reset),
        .we    (wsel[g]),
        .d     (wr.data),
        .q     (regs[g])
      );
    end
  endgenerate

  // Three independent combinational read ports; address 0 hits the zero slot.
  assign ReadData1 = regs[RS];
  assign ReadData2 = regs[RT];
  assign DbgData   = regs[DbgAddr];

endmodule
